traffic_light_monitor: RTL and testbench

- Watches a 3-bit one-hot RGY lamp bus driven by a cyclic lamp controller.
- Checks the encoding, the RED→GREEN→YELLOW→RED order, and per-phase dwell time. Reports per-cycle error pulses and a sticky fault.
- Counts completed cycles.
- Sits on the receiving end of the lamp bus, as the checker/consumer of the controller's `light` output.

---
 rtl/traffic_light_monitor.sv | 150 +++++++++++++++
 tb/tb_traffic_light_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Checker on the receiving end of a one-hot RGY lamp bus: validates encoding,
// RED->GREEN->YELLOW order and per-phase dwell, and counts completed cycles.
module traffic_light_monitor #(
   parameter int CNT_W     = 8,
   parameter int MIN_DWELL = 1,
   parameter int MAX_DWELL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [0:2]       light,
   input  logic             clr_fault,
   output logic [1:0]       phase,
   output logic             locked,
   output logic             err_encoding,
   output logic             err_sequence,
   output logic             err_dwell,
   output logic             fault,
   output logic [CNT_W-1:0] last_dwell,
   output logic [CNT_W-1:0] cycles
);

   typedef enum logic {ACQUIRE, RUN} state_t;

   localparam logic [1:0]       PH_R      = 2'd0;
   localparam logic [1:0]       PH_G      = 2'd1;
   localparam logic [1:0]       PH_Y      = 2'd2;
   localparam logic [1:0]       PH_BAD    = 2'd3;
   localparam logic [CNT_W-1:0] DWELL_SAT = '1;
   localparam logic [31:0]      MIN_LIMIT = 32'(MIN_DWELL);
   localparam logic [31:0]      MAX_LIMIT = 32'(MAX_DWELL + 1);

   state_t           state, state_n;
   logic [0:2]       light_q;
   logic [1:0]       cur, cur_n, dec, cur_succ;
   logic             dec_valid;
   logic [CNT_W-1:0] dwell, dwell_n, dwell_inc;
   logic             first, first_n;
   logic             max_hit, max_hit_n;
   logic [1:0]       phase_n;
   logic             enc_n, seq_n, dw_n, fault_n;
   logic [CNT_W-1:0] last_dwell_n, cycles_n;

   // Anything other than the three one-hot codes (including X) decodes as invalid.
   always_comb begin
      dec       = PH_BAD;
      dec_valid = 1'b0;
      case (light_q)
         3'b100:  begin dec = PH_R; dec_valid = 1'b1; end
         3'b010:  begin dec = PH_G; dec_valid = 1'b1; end
         3'b001:  begin dec = PH_Y; dec_valid = 1'b1; end
         default: begin dec = PH_BAD; dec_valid = 1'b0; end
      endcase
   end

   assign cur_succ  = (cur == PH_Y) ? PH_R : cur + 2'd1;
   assign dwell_inc = (dwell == DWELL_SAT) ? dwell : dwell + CNT_W'(1);

   always_comb begin
      state_n      = state;
      cur_n        = cur;
      dwell_n      = dwell;
      first_n      = first;
      max_hit_n    = max_hit;
      phase_n      = dec;
      enc_n        = 1'b0;
      seq_n        = 1'b0;
      dw_n         = 1'b0;
      last_dwell_n = last_dwell;
      cycles_n     = cycles;
      case (state)
         ACQUIRE: begin
            if (dec_valid) begin
               cur_n     = dec;
               dwell_n   = CNT_W'(1);
               first_n   = 1'b1;
               max_hit_n = 1'b0;
               state_n   = RUN;
            end
         end
         RUN: begin
            if (!dec_valid) begin
               enc_n   = 1'b1;
               state_n = ACQUIRE;
            end else if (dec == cur) begin
               // max_hit keeps the overrun pulse single even if dwell saturates at MAX+1.
               dwell_n = dwell_inc;
               if ((32'(dwell_inc) == MAX_LIMIT) && !max_hit) begin
                  dw_n      = 1'b1;
                  max_hit_n = 1'b1;
               end
            end else begin
               last_dwell_n = dwell;
               if (dec != cur_succ)
                  seq_n = 1'b1;
               if (!first && (32'(dwell) < MIN_LIMIT))
                  dw_n = 1'b1;
               if ((cur == PH_Y) && (dec == PH_R))
                  cycles_n = cycles + CNT_W'(1);
               cur_n     = dec;
               dwell_n   = CNT_W'(1);
               first_n   = 1'b0;
               max_hit_n = 1'b0;
            end
         end
         default: state_n = ACQUIRE;
      endcase
      // A fresh error outranks a clear request arriving at the same edge.
      if (enc_n || seq_n || dw_n)
         fault_n = 1'b1;
      else if (clr_fault)
         fault_n = 1'b0;
      else
         fault_n = fault;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ACQUIRE;
         light_q      <= 3'b000;
         cur          <= PH_R;
         dwell        <= '0;
         first        <= 1'b0;
         max_hit      <= 1'b0;
         phase        <= PH_BAD;
         err_encoding <= 1'b0;
         err_sequence <= 1'b0;
         err_dwell    <= 1'b0;
         fault        <= 1'b0;
         last_dwell   <= '0;
         cycles       <= '0;
      end else begin
         state        <= state_n;
         light_q      <= light;
         cur          <= cur_n;
         dwell        <= dwell_n;
         first        <= first_n;
         max_hit      <= max_hit_n;
         phase        <= phase_n;
         err_encoding <= enc_n;
         err_sequence <= seq_n;
         err_dwell    <= dw_n;
         fault        <= fault_n;
         last_dwell   <= last_dwell_n;
         cycles       <= cycles_n;
      end
   end

   assign locked = (state == RUN);

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: three parameterisations share one lamp stream
// and are compared every cycle against a phase/run-length reference model.
module tb_traffic_light_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [0:2] light = 3'b000;
   logic       clr_fault = 1'b0;

   logic [1:0] phase_a, phase_b, phase_c;
   logic       locked_a, locked_b, locked_c;
   logic       enc_a, enc_b, enc_c;
   logic       seq_a, seq_b, seq_c;
   logic       dw_a, dw_b, dw_c;
   logic       fault_a, fault_b, fault_c;
   logic [7:0] last_a, last_b, cycles_a, cycles_b;
   logic [2:0] last_c, cycles_c;

   traffic_light_monitor #(.CNT_W(8), .MIN_DWELL(1), .MAX_DWELL(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .light(light), .clr_fault(clr_fault),
      .phase(phase_a), .locked(locked_a), .err_encoding(enc_a), .err_sequence(seq_a),
      .err_dwell(dw_a), .fault(fault_a), .last_dwell(last_a), .cycles(cycles_a));

   traffic_light_monitor #(.CNT_W(8), .MIN_DWELL(2), .MAX_DWELL(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .light(light), .clr_fault(clr_fault),
      .phase(phase_b), .locked(locked_b), .err_encoding(enc_b), .err_sequence(seq_b),
      .err_dwell(dw_b), .fault(fault_b), .last_dwell(last_b), .cycles(cycles_b));

   traffic_light_monitor #(.CNT_W(3), .MIN_DWELL(1), .MAX_DWELL(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .light(light), .clr_fault(clr_fault),
      .phase(phase_c), .locked(locked_c), .err_encoding(enc_c), .err_sequence(seq_c),
      .err_dwell(dw_c), .fault(fault_c), .last_dwell(last_c), .cycles(cycles_c));

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_fail = 0;
   bit         check_en = 1'b0;
   logic [0:2] prev_light = 3'b000;
   int         lamp = 0;

   int m_w[3]   = '{8, 8, 3};
   int m_min[3] = '{1, 2, 1};
   int m_max[3] = '{1, 3, 4};
   int m_locked[3], m_cur[3], m_len[3], m_first[3], m_last[3], m_cycles[3], m_fault[3];
   int e_phase[3], e_enc[3], e_seq[3], e_dw[3];

   function automatic int lamp_of(input logic [0:2] l);
      if (l === 3'b100) return 0;
      if (l === 3'b010) return 1;
      if (l === 3'b001) return 2;
      return 3;
   endfunction

   function automatic logic [0:2] lamp_vec(input int p);
      logic [0:2] v;
      case (p)
         0:       v = 3'b100;
         1:       v = 3'b010;
         default: v = 3'b001;
      endcase
      return v;
   endfunction

   task automatic modelReset(input int k);
      m_locked[k] = 0; m_cur[k] = 0; m_len[k] = 0; m_first[k] = 0;
      m_last[k] = 0; m_cycles[k] = 0; m_fault[k] = 0;
      e_phase[k] = 3; e_enc[k] = 0; e_seq[k] = 0; e_dw[k] = 0;
   endtask

   // Phase rules applied to one registered lamp sample; run length is an unbounded int.
   task automatic modelStep(input int k, input logic [0:2] s, input bit clr);
      int p;
      int sat;
      p = lamp_of(s);
      sat = (1 << m_w[k]) - 1;
      e_phase[k] = p; e_enc[k] = 0; e_seq[k] = 0; e_dw[k] = 0;
      if (m_locked[k] == 0) begin
         if (p != 3) begin
            m_locked[k] = 1; m_cur[k] = p; m_len[k] = 1; m_first[k] = 1;
         end
      end else if (p == 3) begin
         e_enc[k] = 1;
         m_locked[k] = 0;
      end else if (p == m_cur[k]) begin
         m_len[k] = m_len[k] + 1;
         if (m_len[k] == m_max[k] + 1) e_dw[k] = 1;
      end else begin
         m_last[k] = (m_len[k] > sat) ? sat : m_len[k];
         if (p != (m_cur[k] + 1) % 3) e_seq[k] = 1;
         if (m_first[k] == 0 && m_len[k] < m_min[k]) e_dw[k] = 1;
         if (m_cur[k] == 2 && p == 0) m_cycles[k] = (m_cycles[k] + 1) % (sat + 1);
         m_cur[k] = p; m_len[k] = 1; m_first[k] = 0;
      end
      if (e_enc[k] || e_seq[k] || e_dw[k]) m_fault[k] = 1;
      else if (clr) m_fault[k] = 0;
   endtask

   task automatic cmp(input string tag, input int k, input int act, input int exp);
      n_cmp++;
      assert (act === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s dut%0d: observed %0d expected %0d", tag, k, act, exp);
      end
   endtask

   task automatic checkInst(input int k, input int ph, input int lk, input int en,
                            input int sq, input int dw, input int ft, input int ld,
                            input int cy);
      cmp("phase", k, ph, e_phase[k]);
      cmp("locked", k, lk, m_locked[k]);
      cmp("err_encoding", k, en, e_enc[k]);
      cmp("err_sequence", k, sq, e_seq[k]);
      cmp("err_dwell", k, dw, e_dw[k]);
      cmp("fault", k, ft, m_fault[k]);
      cmp("last_dwell", k, ld, m_last[k]);
      cmp("cycles", k, cy, m_cycles[k]);
   endtask

   task automatic checkOutput();
      if (check_en) begin
         checkInst(0, int'(phase_a), int'(locked_a), int'(enc_a), int'(seq_a), int'(dw_a),
                   int'(fault_a), int'(last_a), int'(cycles_a));
         checkInst(1, int'(phase_b), int'(locked_b), int'(enc_b), int'(seq_b), int'(dw_b),
                   int'(fault_b), int'(last_b), int'(cycles_b));
         checkInst(2, int'(phase_c), int'(locked_c), int'(enc_c), int'(seq_c), int'(dw_c),
                   int'(fault_c), int'(last_c), int'(cycles_c));
      end
   endtask

   // The sample driven one step earlier is what the monitor evaluates at the coming edge,
   // together with the clr_fault driven now.
   task automatic applyStimulus(input logic [0:2] l, input bit clr, input bit rst);
      @(negedge clk);
      checkOutput();
      light = l;
      clr_fault = clr;
      rst_n = !rst;
      if (lamp_of(l) != 3) lamp = lamp_of(l);
      for (int k = 0; k < 3; k++) begin
         if (rst) modelReset(k);
         else modelStep(k, prev_light, clr);
      end
      prev_light = rst ? 3'b000 : l;
   endtask

   logic [0:2] bad_codes[5] = '{3'b000, 3'b110, 3'b011, 3'b101, 3'b111};

   initial begin
      int r;
      bit clr;
      applyStimulus(3'b000, 1'b0, 1'b1);
      check_en = 1'b1;
      applyStimulus(3'b000, 1'b0, 1'b1);

      $display("[TB] controller stream");
      repeat (3) applyStimulus(3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) applyStimulus(lamp_vec(i % 3), 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b0, 1'b0);

      $display("[TB] reset mid-run");
      applyStimulus(3'b010, 1'b0, 1'b1);
      applyStimulus(3'b100, 1'b1, 1'b1);
      applyStimulus(3'b000, 1'b0, 1'b0);
      applyStimulus(3'b000, 1'b0, 1'b0);
      applyStimulus(3'b110, 1'b0, 1'b0);

      $display("[TB] dwell limits");
      applyStimulus(3'b100, 1'b0, 1'b0);
      applyStimulus(3'b100, 1'b0, 1'b0);
      repeat (3) applyStimulus(3'b010, 1'b0, 1'b0);
      repeat (4) applyStimulus(3'b001, 1'b0, 1'b0);
      applyStimulus(3'b100, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b0, 1'b0);

      $display("[TB] order fault and fault clear");
      applyStimulus(3'b000, 1'b0, 1'b1);
      applyStimulus(3'b100, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b1, 1'b0);
      applyStimulus(3'b100, 1'b1, 1'b0);
      applyStimulus(3'b100, 1'b0, 1'b0);

      $display("[TB] encoding fault");
      applyStimulus(3'b000, 1'b0, 1'b1);
      applyStimulus(3'b100, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b0, 1'b0);
      applyStimulus(3'b110, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b0, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      applyStimulus(3'b100, 1'b0, 1'b0);

      $display("[TB] long hold");
      repeat (10) applyStimulus(3'b100, 1'b0, 1'b0);
      applyStimulus(3'b010, 1'b1, 1'b0);

      $display("[TB] randomized stream");
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         clr = ($urandom_range(0, 99) < 15);
         if (r < 1)       applyStimulus(3'b000, clr, 1'b1);
         else if (r < 6)  applyStimulus(bad_codes[$urandom_range(0, 4)], clr, 1'b0);
         else if (r < 14) applyStimulus(lamp_vec((lamp + 2) % 3), clr, 1'b0);
         else if (r < 45) applyStimulus(lamp_vec(lamp), clr, 1'b0);
         else             applyStimulus(lamp_vec((lamp + 1) % 3), clr, 1'b0);
      end

      applyStimulus(3'b000, 1'b0, 1'b0);
      applyStimulus(3'b000, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
